// File: rtl/pc_unit_pkg.sv
// Shared encodings for the fetch-stage program-counter unit:
// next-PC select codes, branch compare codes and the redirect state.
package pc_unit_pkg;

    localparam logic [3:0] NPC_NORMAL = 4'd0;
    localparam logic [3:0] NPC_BRANCH = 4'd1;
    localparam logic [3:0] NPC_JUMP   = 4'd2;
    localparam logic [3:0] NPC_JREG   = 4'd3;

    localparam logic [2:0] CMP_EQ  = 3'd0;
    localparam logic [2:0] CMP_NE  = 3'd1;
    localparam logic [2:0] CMP_LEZ = 3'd2;
    localparam logic [2:0] CMP_GTZ = 3'd3;
    localparam logic [2:0] CMP_LTZ = 3'd4;
    localparam logic [2:0] CMP_GEZ = 3'd5;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_unit_branch_cmp.sv
// D-stage branch condition evaluator: signed 32-bit compares,
// zero tests look at rs only; unused codes are never taken.
module branch_cmp
    import pc_unit_pkg::*;
(
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [2:0]  cmp_i,
    output logic        cond_o
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_i == 32'd0);
    assign rs_neg  = rs_i[31];

    // Select the condition named by the compare code
    always_comb begin
        cond_o = 1'b0;
        case (cmp_i)
            CMP_EQ:  cond_o = (rs_i == rt_i);
            CMP_NE:  cond_o = (rs_i != rt_i);
            CMP_LEZ: cond_o = rs_neg | rs_zero;
            CMP_GTZ: cond_o = ~rs_neg & ~rs_zero;
            CMP_LTZ: cond_o = rs_neg;
            CMP_GEZ: cond_o = ~rs_neg;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with D-stage branch/jump resolution, exception
// and eret redirects, and a one-entry latch for redirects during imem waits.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [3:0]  D_PCsel,
    input  logic [2:0]  D_cmp,
    input  logic [31:0] D_PC,
    input  logic [31:0] D_extImm,
    input  logic [25:0] D_index,
    input  logic [31:0] D_rsValue,
    input  logic [31:0] D_rtValue,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] EPC,
    output logic [31:0] F_PC,
    output logic        D_taken,
    output logic        F_flush,
    output logic        F_BD,
    output logic        F_adel
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] d_plus4;
    logic [31:0] target;
    logic        cond;
    logic        advance;
    logic        redirect;

    branch_cmp u_cmp (
        .rs_i   (D_rsValue),
        .rt_i   (D_rtValue),
        .cmp_i  (D_cmp),
        .cond_o (cond)
    );

    assign d_plus4 = D_PC + 32'd4;
    assign advance = imem_ready & ~stall;

    // Resolve whether D transfers control and where it goes
    always_comb begin
        D_taken = 1'b0;
        target  = d_plus4;
        case (D_PCsel)
            NPC_BRANCH: begin
                D_taken = cond;
                target  = d_plus4 + (D_extImm << 2);
            end
            NPC_JUMP: begin
                D_taken = 1'b1;
                target  = {d_plus4[31:28], D_index, 2'b00};
            end
            NPC_JREG: begin
                D_taken = 1'b1;
                target  = D_rsValue;
            end
            default: begin
                D_taken = 1'b0;
                target  = d_plus4;
            end
        endcase
        D_taken = D_taken & ~stall;
    end

    // Prioritised next-PC selection; a D transfer seen while a
    // redirect is already pending is dropped (D holds a bubble then)
    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        state_d = state_q;
        if (exc_req) begin
            pc_d    = HANDLER_PC;
            state_d = ST_RUN;
        end else if (eret_req) begin
            pc_d    = EPC;
            state_d = ST_RUN;
        end else if (state_q == ST_PEND) begin
            if (advance) begin
                pc_d    = pend_q;
                state_d = ST_RUN;
            end
        end else if (D_taken && advance) begin
            pc_d = target;
        end else if (D_taken && !imem_ready) begin
            pend_d  = target;
            state_d = ST_PEND;
        end else if (advance) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC, redirect latch and state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    assign redirect = D_taken | (state_q == ST_PEND);
    assign F_PC     = pc_q;
    assign F_adel   = |pc_q[1:0];
    assign F_BD     = DELAY_SLOT ? redirect : 1'b0;
    assign F_flush  = DELAY_SLOT ? 1'b0 : redirect;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic checked
// against a behavioural next-PC model; two instances cover both slot modes.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic [3:0]  D_PCsel;
    logic [2:0]  D_cmp;
    logic [31:0] D_PC;
    logic [31:0] D_extImm;
    logic [25:0] D_index;
    logic [31:0] D_rsValue;
    logic [31:0] D_rtValue;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] EPC;

    logic [31:0] pc1, pc0;
    logic        tk1, tk0, fl1, fl0, bd1, bd0, ad1, ad0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_unit #(.DELAY_SLOT(1'b1)) u_ds1 (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .D_PCsel(D_PCsel), .D_cmp(D_cmp), .D_PC(D_PC), .D_extImm(D_extImm),
        .D_index(D_index), .D_rsValue(D_rsValue), .D_rtValue(D_rtValue),
        .exc_req(exc_req), .eret_req(eret_req), .EPC(EPC),
        .F_PC(pc1), .D_taken(tk1), .F_flush(fl1), .F_BD(bd1), .F_adel(ad1)
    );

    pc_unit #(.DELAY_SLOT(1'b0)) u_ds0 (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .D_PCsel(D_PCsel), .D_cmp(D_cmp), .D_PC(D_PC), .D_extImm(D_extImm),
        .D_index(D_index), .D_rsValue(D_rsValue), .D_rtValue(D_rtValue),
        .exc_req(exc_req), .eret_req(eret_req), .EPC(EPC),
        .F_PC(pc0), .D_taken(tk0), .F_flush(fl0), .F_BD(bd0), .F_adel(ad0)
    );

    task automatic clear_inputs;
        stall = 0; imem_ready = 1; D_PCsel = 0; D_cmp = 0;
        D_PC = 0; D_extImm = 0; D_index = 0; D_rsValue = 0; D_rtValue = 0;
        exc_req = 0; eret_req = 0; EPC = 0;
    endtask

    task automatic set_d(input logic [3:0] sel, input logic [2:0] cmp,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs,
                         input logic [31:0] rt);
        D_PCsel = sel; D_cmp = cmp; D_PC = pc; D_extImm = imm;
        D_index = idx; D_rsValue = rs; D_rtValue = rt;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    // Reset then five advances leaves F_PC at 3014
    task automatic go_to_3014;
        do_reset();
        repeat (5) edge1();
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        #3;
        n_cmp++; if (pc1 !== 32'h3000) begin n_err++; $display("FAIL reset_pc ds1: got %h want 3000", pc1); end
        n_cmp++; if (pc0 !== 32'h3000) begin n_err++; $display("FAIL reset_pc ds0: got %h want 3000", pc0); end
        n_cmp++; if ({bd1, fl1, bd0, fl0} !== 4'b0000) begin n_err++; $display("FAIL reset_bd_flush: got %b want 0000", {bd1, fl1, bd0, fl0}); end
        n_cmp++; if ({ad1, tk1} !== 2'b00) begin n_err++; $display("FAIL reset_adel_taken: got %b want 00", {ad1, tk1}); end
        @(negedge clk);
        reset = 0;
        #1;
        n_cmp++; if (pc1 !== 32'h3000) begin n_err++; $display("FAIL seq0: got %h want 3000", pc1); end
        edge1();
        n_cmp++; if (pc1 !== 32'h3004) begin n_err++; $display("FAIL seq1: got %h want 3004", pc1); end
        edge1();
        n_cmp++; if (pc1 !== 32'h3008) begin n_err++; $display("FAIL seq2: got %h want 3008", pc1); end
    endtask

    task automatic test_beq;
        go_to_3014();
        set_d(4'd1, 3'd0, 32'h3010, 32'd4, 26'd0, 32'd5, 32'd5);
        #1;
        n_cmp++; if ({tk1, bd1, fl1} !== 3'b110) begin n_err++; $display("FAIL beq_taken_bd: got %b want 110", {tk1, bd1, fl1}); end
        edge1();
        n_cmp++; if (pc1 !== 32'h3024) begin n_err++; $display("FAIL beq_target: got %h want 3024", pc1); end
        go_to_3014();
        set_d(4'd1, 3'd0, 32'h3010, 32'd4, 26'd0, 32'd5, 32'd6);
        #1;
        n_cmp++; if ({tk1, bd1} !== 2'b00) begin n_err++; $display("FAIL beq_nt_flags: got %b want 00", {tk1, bd1}); end
        edge1();
        n_cmp++; if (pc1 !== 32'h3018) begin n_err++; $display("FAIL beq_nt_pc: got %h want 3018", pc1); end
    endtask

    task automatic test_beq_wait;
        go_to_3014();
        set_d(4'd1, 3'd0, 32'h3010, 32'd4, 26'd0, 32'd5, 32'd5);
        imem_ready = 0;
        edge1();
        set_d(4'd0, 3'd0, 32'h0, 32'd0, 26'd0, 32'd0, 32'd0);
        #1;
        n_cmp++; if (pc1 !== 32'h3014) begin n_err++; $display("FAIL wait_hold1: got %h want 3014", pc1); end
        n_cmp++; if (bd1 !== 1'b1) begin n_err++; $display("FAIL wait_bd_pend: got %b want 1", bd1); end
        edge1();
        edge1();
        n_cmp++; if (pc1 !== 32'h3014) begin n_err++; $display("FAIL wait_hold3: got %h want 3014", pc1); end
        n_cmp++; if (fl0 !== 1'b1) begin n_err++; $display("FAIL wait_flush_pend: got %b want 1", fl0); end
        imem_ready = 1;
        edge1();
        n_cmp++; if (pc1 !== 32'h3024) begin n_err++; $display("FAIL wait_release: got %h want 3024", pc1); end
        n_cmp++; if (bd1 !== 1'b0) begin n_err++; $display("FAIL wait_bd_run: got %b want 0", bd1); end
        edge1();
        n_cmp++; if (pc1 !== 32'h3028) begin n_err++; $display("FAIL wait_next: got %h want 3028", pc1); end
    endtask

    task automatic test_cmp;
        go_to_3014();
        set_d(4'd1, 3'd5, 32'h3010, 32'd4, 26'd0, 32'hFFFF_FFFF, 32'd0);
        #1;
        n_cmp++; if (tk1 !== 1'b0) begin n_err++; $display("FAIL bgez_neg: got %b want 0", tk1); end
        D_cmp = 3'd4;
        #1;
        n_cmp++; if (tk1 !== 1'b1) begin n_err++; $display("FAIL bltz_neg: got %b want 1", tk1); end
        D_cmp = 3'd6;
        #1;
        n_cmp++; if (tk1 !== 1'b0) begin n_err++; $display("FAIL cmp6: got %b want 0", tk1); end
        set_d(4'd3, 3'd0, 32'h3010, 32'd0, 26'd0, 32'h3001, 32'd0);
        stall = 1;
        #1;
        n_cmp++; if (tk1 !== 1'b0) begin n_err++; $display("FAIL jr_stalled: got %b want 0", tk1); end
        stall = 0;
        edge1();
        n_cmp++; if (pc1 !== 32'h3001) begin n_err++; $display("FAIL jr_target: got %h want 3001", pc1); end
        n_cmp++; if (ad1 !== 1'b1) begin n_err++; $display("FAIL jr_adel: got %b want 1", ad1); end
    endtask

    task automatic test_jump_noslot;
        go_to_3014();
        set_d(4'd2, 3'd0, 32'h3010, 32'd0, 26'h0000C40, 32'd0, 32'd0);
        #1;
        n_cmp++; if ({fl0, bd0} !== 2'b10) begin n_err++; $display("FAIL j_flush: got %b want 10", {fl0, bd0}); end
        edge1();
        set_d(4'd0, 3'd0, 32'h0, 32'd0, 26'd0, 32'd0, 32'd0);
        #1;
        n_cmp++; if (pc0 !== 32'h3100) begin n_err++; $display("FAIL j_target: got %h want 3100", pc0); end
        n_cmp++; if (fl0 !== 1'b0) begin n_err++; $display("FAIL j_flush_once: got %b want 0", fl0); end
    endtask

    task automatic test_exc_eret;
        go_to_3014();
        set_d(4'd1, 3'd0, 32'h3010, 32'd4, 26'd0, 32'd5, 32'd5);
        imem_ready = 0;
        edge1();
        clear_inputs();
        stall = 1;
        imem_ready = 0;
        exc_req = 1;
        edge1();
        clear_inputs();
        #1;
        n_cmp++; if (pc1 !== 32'h4180) begin n_err++; $display("FAIL exc_pc: got %h want 4180", pc1); end
        n_cmp++; if (bd1 !== 1'b0) begin n_err++; $display("FAIL exc_run: got %b want 0", bd1); end
        edge1();
        n_cmp++; if (pc1 !== 32'h4184) begin n_err++; $display("FAIL exc_after: got %h want 4184", pc1); end
        exc_req = 1; eret_req = 1; EPC = 32'h3040;
        edge1();
        n_cmp++; if (pc1 !== 32'h4180) begin n_err++; $display("FAIL exc_eret: got %h want 4180", pc1); end
        exc_req = 0;
        edge1();
        n_cmp++; if (pc1 !== 32'h3040) begin n_err++; $display("FAIL eret_pc: got %h want 3040", pc1); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_pend;
        go_to_3014();
        set_d(4'd1, 3'd0, 32'h3010, 32'd4, 26'd0, 32'd5, 32'd5);
        imem_ready = 0;
        edge1();
        clear_inputs();
        imem_ready = 0;
        #2;
        reset = 1;
        #1;
        n_cmp++; if ({pc1, bd1} !== {32'h3000, 1'b0}) begin n_err++; $display("FAIL rst_pend: got %h/%b want 3000/0", pc1, bd1); end
        @(negedge clk);
        reset = 0;
        imem_ready = 1;
        edge1();
        n_cmp++; if (pc1 !== 32'h3004) begin n_err++; $display("FAIL rst_pend_run: got %h want 3004", pc1); end
    endtask

    task automatic test_random;
        logic [31:0] m_pc, m_pt, m_tgt, m_p4;
        bit          m_pend, m_cond, m_tk, m_adv;
        logic [31:0] pool [6];
        logic [7:0]  b;
        int          r;
        pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'd5;
        do_reset();
        m_pc = 32'h3000;
        m_pt = 32'd0;
        m_pend = 0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            D_PCsel = (r < 7) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            D_cmp = 3'($urandom_range(0, 7));
            D_PC = {$urandom} & 32'hFFFF_FFFC;
            b = 8'($urandom);
            D_extImm = {{24{b[7]}}, b};
            D_index = 26'($urandom);
            D_rsValue = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            D_rtValue = ($urandom_range(0, 1) == 0) ? D_rsValue : $urandom;
            imem_ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 4) == 0);
            exc_req = ($urandom_range(0, 24) == 0);
            eret_req = ($urandom_range(0, 24) == 0);
            EPC = $urandom;
            #1;
            case (D_cmp)
                3'd0: m_cond = (D_rsValue == D_rtValue);
                3'd1: m_cond = (D_rsValue != D_rtValue);
                3'd2: m_cond = ($signed(D_rsValue) <= 0);
                3'd3: m_cond = ($signed(D_rsValue) > 0);
                3'd4: m_cond = ($signed(D_rsValue) < 0);
                3'd5: m_cond = ($signed(D_rsValue) >= 0);
                default: m_cond = 0;
            endcase
            m_tk = !stall && (D_PCsel == 2 || D_PCsel == 3 || (D_PCsel == 1 && m_cond));
            m_p4 = D_PC + 4;
            if (D_PCsel == 1) m_tgt = m_p4 + D_extImm * 4;
            else if (D_PCsel == 2) m_tgt = {m_p4[31:28], D_index, 2'b00};
            else m_tgt = D_rsValue;
            n_cmp++; if ({tk1, tk0} !== {m_tk, m_tk}) begin n_err++; $display("FAIL rnd_taken %0d: got %b want %b", i, {tk1, tk0}, {m_tk, m_tk}); end
            n_cmp++; if ({bd1, fl1, bd0, fl0} !== {m_tk | m_pend, 1'b0, 1'b0, m_tk | m_pend}) begin n_err++; $display("FAIL rnd_bd_flush %0d: got %b", i, {bd1, fl1, bd0, fl0}); end
            m_adv = imem_ready && !stall;
            if (exc_req) begin m_pc = 32'h4180; m_pend = 0; end
            else if (eret_req) begin m_pc = EPC; m_pend = 0; end
            else if (m_pend) begin
                if (m_adv) begin m_pc = m_pt; m_pend = 0; end
            end
            else if (m_tk && m_adv) m_pc = m_tgt;
            else if (m_tk && !imem_ready) begin m_pt = m_tgt; m_pend = 1; end
            else if (m_adv) m_pc = m_pc + 4;
            edge1();
            n_cmp++; if ({pc1, pc0} !== {m_pc, m_pc}) begin n_err++; $display("FAIL rnd_pc %0d: got %h/%h want %h", i, pc1, pc0, m_pc); end
            n_cmp++; if (ad1 !== (m_pc[1:0] != 2'b00)) begin n_err++; $display("FAIL rnd_adel %0d: got %b", i, ad1); end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_beq();
        test_beq_wait();
        test_cmp();
        test_jump_noslot();
        test_exc_eret();
        test_reset_mid_pend();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit for the five-stage MIPS pipeline, and the successor to the purely combinational next-PC selector. It owns the F-stage PC register and resolves D-stage branches (six signed compare conditions), jumps and register jumps. It redirects to the exception handler and to EPC on eret, and optionally implements the branch delay slot. A one-entry redirect latch lets a control transfer resolved in D survive an instruction-memory wait in F.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, F_PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception entry address.
- DELAY_SLOT, 1, 1 = MIPS delay-slot semantics; 0 = taken transfer flushes the F instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hazard-unit freeze of F/D.
- imem_ready  in  1  instruction memory returns the word for F_PC this cycle.
- D_PCsel  in  4  0 normal, 1 branch, 2 jump, 3 jreg; any other value is treated as normal.
- D_cmp  in  3  0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez; 6–7 never taken.
- D_PC  in  32  PC of the D instruction.
- D_extImm  in  32  sign-extended offset.
- D_index  in  26  jump index.
- D_rsValue, D_rtValue  in  32 each  forwarded operands.
- exc_req  in  1  exception/interrupt commit from the CP0 stage.
- eret_req  in  1  eret commit.
- EPC  in  32  return address.
- F_PC  out  32  current fetch address (registered).
- D_taken  out  1  D control transfer is taken (combinational).
- F_flush  out  1  discard the F instruction when it is latched into D.
- F_BD  out  1  the F instruction is a delay slot.
- F_adel  out  1  F_PC[1:0] != 0.

## Operation
- Targets:
  - branch = D_PC + 4 + (D_extImm << 2), mod 2^32.
  - jump = {D_PC_plus4[31:28], D_index, 2'b00}.
  - jreg = D_rsValue.
- Compares are signed, 32-bit. lez/gtz/ltz/gez test rs only.
- D_taken = (sel==jump | sel==jreg | (sel==branch & cond)) & ~stall.
- advance = imem_ready & ~stall.
- States:
  - RUN: no redirect latched.
  - PEND: pend_target is valid.
- Next F_PC, in priority order:
  1. exc_req → HANDLER_PC. Clears PEND. Ignores stall and imem_ready.
  2. eret_req → EPC. Clears PEND. Ignores stall and imem_ready.
  3. PEND & advance → pend_target, then go to RUN.
  4. D_taken & advance → target.
  5. D_taken & ~imem_ready → hold F_PC, latch target, go to PEND.
  6. advance → F_PC + 4.
  7. Otherwise → hold.
- DELAY_SLOT=1:
  - F_BD = D_taken | PEND.
  - F_flush = 0.
- DELAY_SLOT=0:
  - F_BD = 0.
  - F_flush = D_taken | PEND.
- F_adel does not block the fetch. Misaligned jreg targets are loaded and flagged, so the exception is raised downstream.
- A second D_taken while in PEND cannot occur because D holds a bubble. If one does arrive, it is ignored.

## Timing
- Reset values: F_PC = RESET_PC, state = RUN, pend_target = 0, F_BD = 0, F_flush = 0, F_adel = 0.
- D-to-F redirect latency is 1 cycle; the target appears in F_PC on the edge after D_taken.
- With imem_ready low for N cycles, the target appears on the edge after imem_ready returns.
- exc_req and eret_req take effect on the next edge even when stall or PEND is active. exc_req wins if both are asserted.
- Reset asserted mid-PEND returns to RUN immediately (asynchronous).

## Structure
- Package pc_unit_pkg holds the PCsel encodings (NPC_NORMAL, NPC_BRANCH, NPC_JUMP, NPC_JREG) and the compare encodings (CMP_EQ … CMP_GEZ).
- Sub-module branch_cmp: rs, rt, cmp → cond. Purely combinational.
- The parent holds the PC register, the RUN/PEND state bit, pend_target and the next-PC mux.

## Test plan
- Reset release, imem_ready=1, no control: F_PC goes 3000, 3004, 3008 on consecutive edges.
- beq in D (D_PC=3010, imm=4, rs=rt=5), DELAY_SLOT=1: D_taken=1 and F_BD=1; next F_PC=3024. Repeat with rs≠rt: F_PC=3018.
- Same beq with imem_ready=0 for 3 cycles: F_PC holds 3014, state=PEND, F_BD=1. On the first ready edge F_PC=3024.
- bgez with rs=32'hFFFF_FFFF: not taken. bltz with the same rs: taken. jr with rs=3001: F_PC=3001 and F_adel=1.
- DELAY_SLOT=0, j with index=0x0000C40: F_flush=1 for one cycle; next F_PC=3100.
- exc_req while stall=1 and in PEND: next F_PC=4180, state=RUN. exc_req and eret_req together: 4180. eret alone with EPC=3040: F_PC=3040.
